bnn_fc_argmax: RTL and testbench
================================

# bnn_fc_argmax

Classification stage directly downstream of the BNN fully-connected layer. Captures the per-stage score the FC layer presents on each stage-end pulse: one score per output class, five stages per inference. Tracks the running maximum across stages and reports the winning class index once the FC layer signals completion. Output feeds the result/UART reporting logic.

## Interface
Parameters:
- OL, 13, score width; matches FC output width
- NCLASS, 5, classes (FC stages) per inference
- CW, 3, class-index width; must satisfy 2^CW >= NCLASS

Ports:
- iCLK  in  1  system clock, rising edge
- iRST  in  1  reset
  - one clock; reset is synchronous and active-low (iCLK, iRST; polarity and synchronicity fixed)
- iSTART  in  1  new-inference pulse; same strobe that clears the FC layer
- iDATA  in  OL  FC score, unsigned; sampled only when iEND=1
- iEND  in  1  FC stage-end pulse, one cycle per stage
- iFINISH  in  1  FC all-stages-done pulse
- oCLASS  out  CW  winning class index
- oSCORE  out  OL  winning score
- oVALID  out  1  one-cycle result strobe
- oBUSY  out  1  high in COLLECT and WAIT_FIN
- oERR  out  1  sticky protocol error for the current inference

## Operation
State machine states:
- IDLE
- COLLECT
- WAIT_FIN
- DONE

Transitions:
- IDLE -> COLLECT on iSTART.
- COLLECT: each iEND captures iDATA as class cnt, then cnt++.
  - cnt reaching NCLASS -> WAIT_FIN.
- WAIT_FIN -> DONE on iFINISH.
- DONE -> IDLE after one cycle.

Running-max update on each captured score (unsigned compare):
- iDATA > best: best<=iDATA, idx<=cnt.
- Strict compare: ties keep the lower index.
- best and idx are cleared to 0 on iSTART, so an all-zero inference yields class 0.

oCLASS and oSCORE:
- Loaded from idx and best on entry to DONE.
- Held until the next iSTART, which clears both to 0.

Boundary conditions:
- iSTART in any state:
  - restarts: cnt=0, best=0, idx=0, oERR=0, state=COLLECT.
  - iSTART has priority over a coincident iEND or iFINISH; the coincident event is ignored.
- iFINISH in COLLECT (cnt < NCLASS):
  - oERR<=1, go to DONE.
  - Result reflects the stages captured so far.
- iEND in WAIT_FIN (extra stage): oERR<=1; data ignored; cnt does not wrap.
- iEND or iFINISH in IDLE/DONE: ignored, no error.
- Reset mid-operation: IDLE, all registers cleared, no oVALID.

Width rules:
- cnt is CW bits.
- Compare is OL-bit unsigned; no saturation is needed.

## Timing
- Reset values: oCLASS=0, oSCORE=0, oVALID=0, oBUSY=0, oERR=0; state IDLE.
- Capture: iDATA registered on the iCLK edge where iEND=1. The running max is updated on the same edge.
- Latency: oVALID high exactly one cycle, in the cycle after iFINISH is sampled.
  - oCLASS and oSCORE are valid in that same cycle and afterward.
- The FC layer issues its last iEND one cycle before iFINISH. The block must accept back-to-back iEND then iFINISH.
- The last iEND and the DONE entry may be adjacent; no bubble is required.
- oBUSY:
  - Rises the cycle after iSTART.
  - Falls in the DONE cycle.
- oERR:
  - Sets the cycle after the offending event.
  - Holds until iSTART or reset.

## Configuration
- BNN_FC_ARGMAX_MARGIN_EN defined:
  - Adds output oMARGIN [OL-1:0] = best - second.
  - second is the maximum of the non-winning scores.
  - Tracking: on a new best, second<=old best; else if iDATA > second, second<=iDATA.
  - second clears to 0 on iSTART.
  - Tie for first gives oMARGIN=0.
  - oMARGIN is valid and held alongside oCLASS; reset value 0.
- Undefined: no oMARGIN port, no second-best register.

## Structure
- Shared package bnn_pkg holds:
  - NCLASS and CW constants
  - state encoding localparams: IDLE=2'd0, COLLECT=2'd1, WAIT_FIN=2'd2, DONE=2'd3
- One sub-module, bnn_max_tracker:
  - Holds the compare/update of best, idx and, under the macro, second.
  - Inputs: clear, capture enable, data, index.
- The top holds the FSM, stage counter, error logic and output registers.

## Test plan
- Scores 100,250,30,250,7 then iFINISH -> oVALID one cycle after iFINISH; oCLASS=1, oSCORE=250; with macro, oMARGIN=0.
- Scores 10,20,30,40,900 -> oCLASS=4, oSCORE=900; with macro, oMARGIN=860.
- Three iEND (5,9,3), then iFINISH -> oERR=1, oCLASS=1, oSCORE=9, oVALID pulses.
- Five iEND, a sixth iEND, then iFINISH -> oERR=1; the sixth iDATA=8191 does not affect the result.
- iSTART after two stages, then a full five-stage inference (1,2,3,4,5) -> oERR=0, oCLASS=4, oSCORE=5.
- iRST low during COLLECT -> next cycle all outputs 0, oBUSY=0, no oVALID; a following iFINISH is ignored.

Source files
------------

// File: rtl/bnn_pkg.sv
// Shared constants and FSM state encoding for the BNN classification stage.
package bnn_pkg;
  localparam int NCLASS = 5;
  localparam int CW     = 3;

  typedef logic [1:0] state_t;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] COLLECT  = 2'd1;
  localparam logic [1:0] WAIT_FIN = 2'd2;
  localparam logic [1:0] DONE     = 2'd3;
endpackage

// File: rtl/bnn_fc_argmax_if.sv
// FC-score / argmax-result bundle; oMARGIN exists only with BNN_FC_ARGMAX_MARGIN_EN.
interface bnn_fc_argmax_if #(
  parameter int OL = 13,
  parameter int CW = 3
);
  logic          iSTART;
  logic [OL-1:0] iDATA;
  logic          iEND;
  logic          iFINISH;
  logic [CW-1:0] oCLASS;
  logic [OL-1:0] oSCORE;
  logic          oVALID;
  logic          oBUSY;
  logic          oERR;
`ifdef BNN_FC_ARGMAX_MARGIN_EN
  logic [OL-1:0] oMARGIN;

  modport master (output iSTART, iDATA, iEND, iFINISH,
                  input  oCLASS, oSCORE, oVALID, oBUSY, oERR, oMARGIN);
  modport slave  (input  iSTART, iDATA, iEND, iFINISH,
                  output oCLASS, oSCORE, oVALID, oBUSY, oERR, oMARGIN);
`else
  modport master (output iSTART, iDATA, iEND, iFINISH,
                  input  oCLASS, oSCORE, oVALID, oBUSY, oERR);
  modport slave  (input  iSTART, iDATA, iEND, iFINISH,
                  output oCLASS, oSCORE, oVALID, oBUSY, oERR);
`endif
endinterface

// File: rtl/bnn_max_tracker.sv
// Running unsigned maximum with index (and second-best under BNN_FC_ARGMAX_MARGIN_EN).
// Updates on the same edge as capEn; clear wins over capture; no backpressure.
module bnn_max_tracker #(
  parameter int OL = 13,
  parameter int CW = 3
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          clear,
  input  logic          capEn,
  input  logic [OL-1:0] data,
  input  logic [CW-1:0] index,
`ifdef BNN_FC_ARGMAX_MARGIN_EN
  output logic [OL-1:0] second,
`endif
  output logic [OL-1:0] best,
  output logic [CW-1:0] idx
);
  always_ff @(posedge iCLK) begin
    if (!iRST || clear) begin
      best <= '0;
      idx  <= '0;
`ifdef BNN_FC_ARGMAX_MARGIN_EN
      second <= '0;
`endif
    end else if (capEn) begin
      // Strict compare so an equal later score never steals the lower index.
      if (data > best) begin
        best <= data;
        idx  <= index;
`ifdef BNN_FC_ARGMAX_MARGIN_EN
        second <= best;
`endif
      end
`ifdef BNN_FC_ARGMAX_MARGIN_EN
      else if (data > second) begin
        second <= data;
      end
`endif
    end
  end
endmodule

// File: rtl/bnn_fc_argmax.sv
// Argmax over NCLASS FC stage scores; result one cycle after iFINISH; no backpressure.
// BNN_FC_ARGMAX_MARGIN_EN adds oMARGIN = best - second best.
module bnn_fc_argmax #(
  parameter int OL     = 13,
  parameter int NCLASS = bnn_pkg::NCLASS,
  parameter int CW     = bnn_pkg::CW
) (
  input  logic            iCLK,
  input  logic            iRST,
  bnn_fc_argmax_if.slave  bus
);
  import bnn_pkg::*;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [OL-1:0] best;
  logic [CW-1:0] idx;
  logic          capEn;
`ifdef BNN_FC_ARGMAX_MARGIN_EN
  logic [OL-1:0] second;
`endif

  // iSTART and an early iFINISH both pre-empt a coincident capture.
  assign capEn    = bus.iEND && !bus.iSTART && !bus.iFINISH && (state == COLLECT);
  assign bus.oBUSY = (state == COLLECT) || (state == WAIT_FIN);

  bnn_max_tracker #(.OL(OL), .CW(CW)) uTracker (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .clear  (bus.iSTART),
    .capEn  (capEn),
    .data   (bus.iDATA),
    .index  (cnt),
`ifdef BNN_FC_ARGMAX_MARGIN_EN
    .second (second),
`endif
    .best   (best),
    .idx    (idx)
  );

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      state      <= IDLE;
      cnt        <= '0;
      bus.oCLASS <= '0;
      bus.oSCORE <= '0;
      bus.oVALID <= 1'b0;
      bus.oERR   <= 1'b0;
`ifdef BNN_FC_ARGMAX_MARGIN_EN
      bus.oMARGIN <= '0;
`endif
    end else begin
      bus.oVALID <= 1'b0;
      if (bus.iSTART) begin
        state      <= COLLECT;
        cnt        <= '0;
        bus.oCLASS <= '0;
        bus.oSCORE <= '0;
        bus.oERR   <= 1'b0;
`ifdef BNN_FC_ARGMAX_MARGIN_EN
        bus.oMARGIN <= '0;
`endif
      end else begin
        case (state)
          COLLECT: begin
            if (bus.iFINISH) begin
              bus.oERR <= 1'b1;
            end else if (bus.iEND) begin
              cnt <= cnt + CW'(1);
              if (cnt == CW'(NCLASS - 1)) state <= WAIT_FIN;
            end
          end
          WAIT_FIN: begin
            if (!bus.iFINISH && bus.iEND) bus.oERR <= 1'b1;
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
        // Result load on DONE entry, shared by normal and early finish.
        if (bus.iFINISH && (state == COLLECT || state == WAIT_FIN)) begin
          state      <= DONE;
          bus.oCLASS <= idx;
          bus.oSCORE <= best;
          bus.oVALID <= 1'b1;
`ifdef BNN_FC_ARGMAX_MARGIN_EN
          bus.oMARGIN <= best - second;
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_bnn_fc_argmax.sv
// Directed bench for bnn_fc_argmax; margin checks compile in with BNN_FC_ARGMAX_MARGIN_EN.
module tb_bnn_fc_argmax;
  logic iCLK;
  logic iRST;
  int   nPass;
  int   nChk;

  bnn_fc_argmax_if #(.OL(13), .CW(3)) bif ();

  bnn_fc_argmax #(.OL(13), .NCLASS(5), .CW(3)) dut (
    .iCLK (iCLK),
    .iRST (iRST),
    .bus  (bif.slave)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChk++;
    assert (obs === exp) nPass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic startPulse();
    bif.iSTART = 1'b1;
    tick();
    bif.iSTART = 1'b0;
  endtask

  task automatic endPulse(input logic [12:0] d);
    bif.iEND  = 1'b1;
    bif.iDATA = d;
    tick();
    bif.iEND  = 1'b0;
    bif.iDATA = '0;
  endtask

  task automatic finishPulse();
    bif.iFINISH = 1'b1;
    tick();
    bif.iFINISH = 1'b0;
  endtask

  initial begin
    nPass = 0;
    nChk  = 0;
    iRST  = 1'b0;
    bif.iSTART  = 1'b0;
    bif.iDATA   = '0;
    bif.iEND    = 1'b0;
    bif.iFINISH = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_class", 32'(bif.oCLASS), 0);
    check("rst_score", 32'(bif.oSCORE), 0);
    check("rst_valid", 32'(bif.oVALID), 0);
    check("rst_busy",  32'(bif.oBUSY),  0);
    check("rst_err",   32'(bif.oERR),   0);
    iRST = 1'b1;
    tick();

    // Tie for first keeps the lower index
    startPulse();
    check("t1_busy_rise", 32'(bif.oBUSY), 1);
    endPulse(13'd100); endPulse(13'd250); endPulse(13'd30); endPulse(13'd250); endPulse(13'd7);
    check("t1_busy_wait", 32'(bif.oBUSY), 1);
    check("t1_no_valid",  32'(bif.oVALID), 0);
    finishPulse();
    check("t1_valid", 32'(bif.oVALID), 1);
    check("t1_class", 32'(bif.oCLASS), 1);
    check("t1_score", 32'(bif.oSCORE), 250);
    check("t1_busy_done", 32'(bif.oBUSY), 0);
    check("t1_err", 32'(bif.oERR), 0);
`ifdef BNN_FC_ARGMAX_MARGIN_EN
    check("t1_margin", 32'(bif.oMARGIN), 0);
`endif
    tick();
    check("t1_valid_drop", 32'(bif.oVALID), 0);
    check("t1_class_hold", 32'(bif.oCLASS), 1);
    check("t1_score_hold", 32'(bif.oSCORE), 250);

    // Rising scores, last stage wins
    startPulse();
    check("t2_class_clr", 32'(bif.oCLASS), 0);
    check("t2_score_clr", 32'(bif.oSCORE), 0);
    endPulse(13'd10); endPulse(13'd20); endPulse(13'd30); endPulse(13'd40); endPulse(13'd900);
    finishPulse();
    check("t2_valid", 32'(bif.oVALID), 1);
    check("t2_class", 32'(bif.oCLASS), 4);
    check("t2_score", 32'(bif.oSCORE), 900);
`ifdef BNN_FC_ARGMAX_MARGIN_EN
    check("t2_margin", 32'(bif.oMARGIN), 860);
`endif
    tick();

    // Early finish after three stages
    startPulse();
    endPulse(13'd5); endPulse(13'd9); endPulse(13'd3);
    check("t3_no_err_yet", 32'(bif.oERR), 0);
    finishPulse();
    check("t3_valid", 32'(bif.oVALID), 1);
    check("t3_err",   32'(bif.oERR),   1);
    check("t3_class", 32'(bif.oCLASS), 1);
    check("t3_score", 32'(bif.oSCORE), 9);
    tick();
    check("t3_err_sticky", 32'(bif.oERR), 1);
    startPulse();
    check("t3_err_clr", 32'(bif.oERR), 0);

    // Extra sixth stage is an error and its data is dropped
    endPulse(13'd50); endPulse(13'd60); endPulse(13'd70); endPulse(13'd80); endPulse(13'd90);
    check("t4_err_before", 32'(bif.oERR), 0);
    endPulse(13'd8191);
    check("t4_err_extra", 32'(bif.oERR), 1);
    check("t4_busy", 32'(bif.oBUSY), 1);
    finishPulse();
    check("t4_valid", 32'(bif.oVALID), 1);
    check("t4_class", 32'(bif.oCLASS), 4);
    check("t4_score", 32'(bif.oSCORE), 90);
    check("t4_err",   32'(bif.oERR),   1);
    tick();

    // Restart mid-inference with a coincident iEND that must be ignored
    startPulse();
    endPulse(13'd700); endPulse(13'd800);
    bif.iSTART = 1'b1;
    bif.iEND   = 1'b1;
    bif.iDATA  = 13'd8000;
    tick();
    bif.iSTART = 1'b0;
    bif.iEND   = 1'b0;
    bif.iDATA  = '0;
    check("t5_busy", 32'(bif.oBUSY), 1);
    endPulse(13'd1); endPulse(13'd2); endPulse(13'd3); endPulse(13'd4); endPulse(13'd5);
    finishPulse();
    check("t5_valid", 32'(bif.oVALID), 1);
    check("t5_err",   32'(bif.oERR),   0);
    check("t5_class", 32'(bif.oCLASS), 4);
    check("t5_score", 32'(bif.oSCORE), 5);
`ifdef BNN_FC_ARGMAX_MARGIN_EN
    check("t5_margin", 32'(bif.oMARGIN), 1);
`endif
    tick();

    // Reset during COLLECT, then stray iFINISH/iEND in IDLE
    startPulse();
    endPulse(13'd5); endPulse(13'd6);
    iRST = 1'b0;
    tick();
    check("t6_class", 32'(bif.oCLASS), 0);
    check("t6_score", 32'(bif.oSCORE), 0);
    check("t6_valid", 32'(bif.oVALID), 0);
    check("t6_busy",  32'(bif.oBUSY),  0);
    check("t6_err",   32'(bif.oERR),   0);
    iRST = 1'b1;
    finishPulse();
    check("t6_fin_valid", 32'(bif.oVALID), 0);
    check("t6_fin_err",   32'(bif.oERR),   0);
    check("t6_fin_busy",  32'(bif.oBUSY),  0);
    endPulse(13'd10);
    check("t6_end_busy", 32'(bif.oBUSY), 0);
    check("t6_end_err",  32'(bif.oERR),  0);
    tick();
    check("t6_end_valid", 32'(bif.oVALID), 0);

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end
endmodule
